// File: rtl/car_traffic.sv
// Traffic lane animator: a programmable-period tick launches an 8-cycle sweep
// that moves each car one step, alternating direction per lane, wrapping at H_DISPLAY.
module car_traffic #(
  parameter int unsigned H_DISPLAY   = 640,
  parameter int unsigned CAR_STEP    = 4,
  parameter int unsigned BASE_PERIOD = 400000,
  parameter int unsigned PERIOD_STEP = 12000,
  parameter int unsigned MIN_PERIOD  = 40000
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [4:0] speed_car,
  input  logic       run,
  output logic [9:0] car_x1,
  output logic [9:0] car_x2,
  output logic [9:0] car_x3,
  output logic [9:0] car_x4,
  output logic [9:0] car_x5,
  output logic [9:0] car_x6,
  output logic [9:0] car_x7,
  output logic [9:0] car_x8,
  output logic       update_busy
);

  localparam int unsigned CNT_W     = 23;
  localparam int unsigned POS_W     = 10;
  localparam int unsigned NCARS     = 8;
  localparam int unsigned SPAN      = BASE_PERIOD - MIN_PERIOD;
  localparam logic [10:0] HD        = 11'(H_DISPLAY);
  localparam logic [10:0] STEP_SLOW = 11'(CAR_STEP);
  localparam logic [10:0] STEP_FAST = 11'(2 * CAR_STEP);

  typedef enum logic {IDLE, SWEEP} state_t;

  state_t             state_q, state_d;
  logic [2:0]         idx_q, idx_d;
  logic [CNT_W-1:0]   cnt_q, period_q, period_c;
  logic [31:0]        prod_c;
  logic               tick_c;
  logic [POS_W-1:0]   pos_q [NCARS];
  logic [10:0]        cur_c, step_c, sum_c;
  logic [POS_W-1:0]   new_c;
  logic               busy_q;

  // Period for the speed sampled at wrap, clamped without underflow
  always_comb begin
    prod_c = 32'(speed_car) * PERIOD_STEP;
    if (prod_c > SPAN) period_c = CNT_W'(MIN_PERIOD);
    else               period_c = CNT_W'(BASE_PERIOD - prod_c);
  end

  assign tick_c = run && (cnt_q == period_q - CNT_W'(1));

  always_ff @(posedge CLK) begin
    if (RST) begin
      cnt_q    <= '0;
      period_q <= CNT_W'(BASE_PERIOD);
    end else if (run) begin
      if (tick_c) begin
        cnt_q    <= '0;
        period_q <= period_c;
      end else begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

  // Sweep FSM state register
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      idx_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      busy_q  <= (state_d == SWEEP);
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      IDLE: begin
        if (tick_c) begin
          state_d = SWEEP;
          idx_d   = '0;
        end
      end
      SWEEP: begin
        idx_d = idx_q + 3'd1;
        if (idx_q == 3'd7) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Even indices (cars 1,3,5,7) move right; upper four cars move at double step
  always_comb begin
    cur_c  = {1'b0, pos_q[idx_q]};
    step_c = idx_q[2] ? STEP_FAST : STEP_SLOW;
    sum_c  = cur_c;
    if (!idx_q[0]) begin
      sum_c = cur_c + step_c;
      if (sum_c >= HD) sum_c = sum_c - HD;
    end else if (cur_c < step_c) begin
      sum_c = cur_c + HD - step_c;
    end else begin
      sum_c = cur_c - step_c;
    end
    new_c = POS_W'(sum_c);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < NCARS; i++) pos_q[i] <= POS_W'(i * 80);
    end else if (state_q == SWEEP) begin
      pos_q[idx_q] <= new_c;
    end
  end

  assign car_x1      = pos_q[0];
  assign car_x2      = pos_q[1];
  assign car_x3      = pos_q[2];
  assign car_x4      = pos_q[3];
  assign car_x5      = pos_q[4];
  assign car_x6      = pos_q[5];
  assign car_x7      = pos_q[6];
  assign car_x8      = pos_q[7];
  assign update_busy = busy_q;

endmodule

// File: tb/tb_car_traffic.sv
// Bench for car_traffic: directed phases plus randomized traffic, checked every
// cycle against a countdown/modulo reference model.
module tb_car_traffic;

  localparam int H     = 640;
  localparam int BASE  = 100;
  localparam int PSTEP = 10;
  localparam int MINP  = 20;
  localparam int STEP  = 4;

  logic       CLK = 1'b0;
  logic       RST;
  logic [4:0] speed_car;
  logic       run;
  logic [9:0] x1, x2, x3, x4, x5, x6, x7, x8;
  logic       update_busy;
  logic [9:0] obs [8];

  int checks   = 0;
  int failures = 0;

  int m_pos [8];
  int m_left;
  int m_sweep;

  car_traffic #(
    .H_DISPLAY(H), .CAR_STEP(STEP), .BASE_PERIOD(BASE),
    .PERIOD_STEP(PSTEP), .MIN_PERIOD(MINP)
  ) dut (
    .CLK(CLK), .RST(RST), .speed_car(speed_car), .run(run),
    .car_x1(x1), .car_x2(x2), .car_x3(x3), .car_x4(x4),
    .car_x5(x5), .car_x6(x6), .car_x7(x7), .car_x8(x8),
    .update_busy(update_busy)
  );

  always #5 CLK = ~CLK;

  assign obs[0] = x1; assign obs[1] = x2; assign obs[2] = x3; assign obs[3] = x4;
  assign obs[4] = x5; assign obs[5] = x6; assign obs[6] = x7; assign obs[7] = x8;

  function automatic int period_of(int sp);
    int p;
    p = BASE - sp * PSTEP;
    return (p < MINP) ? MINP : p;
  endfunction

  // Reference: cycles left until the next tick, sweep cursor, modulo positions
  task automatic model_edge();
    int k, s;
    if (RST) begin
      for (int i = 0; i < 8; i++) m_pos[i] = i * 80;
      m_left  = BASE;
      m_sweep = -1;
      return;
    end
    if (m_sweep >= 0) begin
      k = m_sweep;
      s = (k < 4) ? STEP : 2 * STEP;
      if (k % 2 == 0) m_pos[k] = (m_pos[k] + s) % H;
      else            m_pos[k] = (m_pos[k] - s + H) % H;
      m_sweep = (k == 7) ? -1 : k + 1;
    end
    if (run) begin
      if (m_left == 1) begin
        m_sweep = 0;
        m_left  = period_of(int'(speed_car));
      end else begin
        m_left--;
      end
    end
  endtask

  task automatic check_all(input string tag);
    checks++;
    assert (update_busy === (m_sweep >= 0)) else begin
      failures++;
      $error("FAIL %s busy: observed=%0b expected=%0b", tag, update_busy, (m_sweep >= 0));
    end
    for (int i = 0; i < 8; i++) begin
      checks++;
      assert (obs[i] === 10'(m_pos[i])) else begin
        failures++;
        $error("FAIL %s car_x%0d: observed=%0d expected=%0d", tag, i + 1, obs[i], m_pos[i]);
      end
    end
  endtask

  task automatic cyc(input string tag);
    @(posedge CLK);
    model_edge();
    @(negedge CLK);
    check_all(tag);
  endtask

  task automatic cycles(input int n, input string tag);
    for (int i = 0; i < n; i++) cyc(tag);
  endtask

  initial begin
    int guard;
    int waited;
    RST = 1'b1; run = 1'b1; speed_car = 5'd0;
    m_sweep = -1; m_left = BASE;
    for (int i = 0; i < 8; i++) m_pos[i] = i * 80;

    // Reset values
    cycles(2, "reset");
    checks++;
    assert (x8 === 10'd560) else begin
      failures++;
      $error("FAIL reset_x8: observed=%0d expected=560", x8);
    end
    RST = 1'b0;

    // Speed 0: first tick exactly BASE cycles after release, then an 8-cycle sweep
    waited = 0;
    while (update_busy !== 1'b1 && waited < 300) begin
      cyc("speed0");
      waited++;
    end
    checks++;
    assert (waited === BASE) else begin
      failures++;
      $error("FAIL first_tick_latency: observed=%0d expected=%0d", waited, BASE);
    end
    cycles(8, "speed0_sweep");
    checks++;
    assert (x1 === 10'd4 && x2 === 10'd76 && x5 === 10'd328 && x6 === 10'd392) else begin
      failures++;
      $error("FAIL speed0_positions: observed=%0d,%0d,%0d,%0d expected=4,76,328,392",
             x1, x2, x5, x6);
    end

    // Speed change then clamp
    speed_car = 5'd5;
    cycles(300, "speed5");
    speed_car = 5'd31;
    cycles(200, "speed31");

    // Freeze between ticks
    guard = 0;
    while (update_busy !== 1'b1 && guard < 200) begin cyc("pre_freeze"); guard++; end
    cycles(12, "pre_freeze");
    run = 1'b0;
    cycles(500, "frozen");
    run = 1'b1;
    cycles(60, "thaw");

    // Run dropped mid-sweep: sweep still completes
    guard = 0;
    while (update_busy !== 1'b1 && guard < 200) begin cyc("pre_drop"); guard++; end
    cycles(2, "drop_mid_sweep");
    run = 1'b0;
    cycles(30, "drop_mid_sweep");
    run = 1'b1;

    // Reset mid-sweep
    guard = 0;
    while (update_busy !== 1'b1 && guard < 200) begin cyc("pre_rst"); guard++; end
    checks++;
    assert (guard < 200) else begin
      failures++;
      $error("FAIL sweep_wait_timeout: observed=%0d expected<200", guard);
    end
    cycles(3, "mid_sweep");
    RST = 1'b1;
    cyc("rst_mid_sweep");
    RST = 1'b0;
    checks++;
    assert (x1 === 10'd0 && x3 === 10'd160 && update_busy === 1'b0) else begin
      failures++;
      $error("FAIL rst_mid_sweep: observed=%0d,%0d,%0b expected=0,160,0", x1, x3, update_busy);
    end

    // Randomized traffic: long enough for every lane to wrap repeatedly
    speed_car = 5'd31;
    for (int i = 0; i < 40000; i++) begin
      if ($urandom_range(0, 59) == 0)
        speed_car = ($urandom_range(0, 1) == 0) ? 5'd31 : 5'($urandom_range(0, 31));
      run = ($urandom_range(0, 19) != 0);
      RST = ($urandom_range(0, 9999) == 0);
      cyc("random");
    end
    RST = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/car_traffic.md
CAR_TRAFFIC -- requirements
Module: car_traffic

Interface
REQ-001 The block SHALL have parameter H_DISPLAY, default 640: visible width in pixels; the wrap modulus.
REQ-002 The block SHALL have parameter CAR_STEP, default 4: pixels per move for cars 1-4; cars 5-8 move 2*CAR_STEP.
REQ-003 The block SHALL have parameter BASE_PERIOD, default 400000: clocks per move tick at speed 0.
REQ-004 The block SHALL have parameter PERIOD_STEP, default 12000: clocks removed from the period per speed unit.
REQ-005 The block SHALL have parameter MIN_PERIOD, default 40000: lower clamp on the period, with legal values >= 16.
REQ-006 The block SHALL have port CLK, input, 1 bit: the single clock.
REQ-007 The block SHALL have port RST, input, 1 bit: synchronous, active-high reset.
REQ-008 The block SHALL have port speed_car, input, 5 bits: the level speed index from player control.
REQ-009 The block SHALL have port run, input, 1 bit: when low, traffic is frozen.
REQ-010 The block SHALL have ports car_x1 to car_x8, output, 10 bits each: registered car x positions, each in the range 0 to H_DISPLAY-1.
REQ-011 The block SHALL have port update_busy, output, 1 bit: high while a position sweep is in progress.

Function
REQ-012 The period counter SHALL be 23 bits wide, with period = BASE_PERIOD - speed_car*PERIOD_STEP, computed without underflow and clamped to a minimum of MIN_PERIOD.
REQ-013 speed_car SHALL be sampled only when the counter wraps; a change mid-period SHALL take effect from the next period.
REQ-014 While run=1 the counter SHALL count 0 to period-1, assert a one-cycle tick at period-1 and then return to 0.
REQ-015 While run=0 the counter SHALL hold its value and no tick SHALL occur.
REQ-016 The FSM SHALL have states IDLE and SWEEP, and it SHALL move from IDLE to SWEEP on tick with car index 0.
REQ-017 In SWEEP the FSM SHALL update exactly one car per cycle, indices 0 to 7 in order, and SHALL return to IDLE after index 7, so a sweep takes 8 cycles.
REQ-018 update_busy SHALL be 1 exactly in SWEEP.
REQ-019 After a tick at cycle T, car_x(k) SHALL show its new value at cycle T+k.
REQ-020 Cars 1, 3, 5 and 7 SHALL move rightward: new = x+s, or x+s-H_DISPLAY when x+s >= H_DISPLAY.
REQ-021 Cars 2, 4, 6 and 8 SHALL move leftward: new = x-s, or x+H_DISPLAY-s when x < s.
REQ-022 All position arithmetic SHALL be 11 bits wide and truncated to 10 bits only after the wrap, so no output ever reaches or exceeds H_DISPLAY.
REQ-023 A car whose update is pending in the current sweep SHALL hold its old value.
REQ-024 Cars not addressed in the current cycle SHALL hold their value.
REQ-025 A tick arriving during SWEEP cannot occur, because the period is at least 16; the design SHALL NOT queue ticks.
REQ-026 If run falls during SWEEP, the sweep SHALL complete, and only the counter SHALL freeze.

Reset
REQ-027 With RST=1 at a clock edge, car_x(k) SHALL be set to (k-1)*80, i.e. 0, 80, 160, 240, 320, 400, 480, 560.
REQ-028 With RST=1 at a clock edge, the counter SHALL be set to 0, the latched period to BASE_PERIOD, the FSM to IDLE and update_busy to 0.
REQ-029 RST SHALL take priority over tick, sweep and run.
REQ-030 RST asserted mid-sweep SHALL abort the sweep and reinitialise every position, including cars already updated.
REQ-031 The first tick after RST SHALL use the speed_car value present at the first counter wrap, and the first period SHALL use BASE_PERIOD.

Verification
(Bench parameters: BASE_PERIOD=100, PERIOD_STEP=10, MIN_PERIOD=20, CAR_STEP=4.)
REQ-032 Reset check: pulse RST with run=1 -> outputs 0, 80, 160, 240, 320, 400, 480, 560; update_busy=0.
REQ-033 Speed 0 sweep: speed_car=0, run=1 after reset -> tick 100 cycles after reset release; over the next 8 cycles car_x1 0->4, car_x2 80->76, car_x5 320->328, car_x6 400->392; update_busy high for exactly 8 cycles.
REQ-034 Speed change and clamp: speed_car=5 -> period 50 starting with the period after the next wrap; speed_car=31 -> period clamps to 20, never 0 or negative.
REQ-035 Wrap check: force car_x1 to 636 and car_x2 to 0 -> after one sweep car_x1=0 and car_x2=636; force car_x7 to 635 (step 8) -> car_x7=3.
REQ-036 Freeze check: drop run for 500 cycles between ticks -> no position change and counter held; raise run -> the tick arrives after the remaining count only.
REQ-037 Reset mid-sweep: assert RST at sweep cycle 3 -> all eight positions return to their reset values next cycle and update_busy=0.
